// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter. Accepts an N-bit word on a valid/ready
// handshake and sends it LSB first, one bit per clock. Back-to-back words
// stream without an idle gap because a new word can be loaded during the
// last bit of the current one.
module shift_piso_tx #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         s_out,
  output logic         s_valid,
  output logic         done_tick
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e         state;
  logic [N-1:0]   sr;
  logic [CW-1:0]  cnt;
  logic           last_bit;
  logic           accept;

  // Handshake and line outputs, derived only from registered state.
  always_comb begin
    last_bit   = (state == StShift) && (cnt == LastCnt);
    load_ready = (state == StIdle) || last_bit;
    accept     = load_valid && load_ready;
    s_valid    = (state == StShift);
    s_out      = (state == StShift) ? sr[0] : 1'b0;
    done_tick  = last_bit;
  end

  // FSM, shift register and bit counter; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            sr    <= din;
            cnt   <= '0;
            state <= StShift;
          end
        end
        StShift: begin
          if (!last_bit) begin
            sr  <= {1'b0, sr[N-1:1]};
            cnt <= cnt + CW'(1);
          end else if (accept) begin
            // Reload on the last bit so the next word follows without a gap.
            sr  <= din;
            cnt <= '0;
          end else begin
            state <= StIdle;
            cnt   <= '0;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
